// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture/display pair: capture FSM states,
// sample RAM geometry and the signed-to-offset-binary conversion.
package wave_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int RAM_AW      = 9;
  localparam int CAPTURE_LEN = 256;
  localparam int OFFSET_W    = RAM_AW - 1;
  localparam int PIXEL_W     = 8;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } cap_state_e;

  // Upper byte of the sample with the sign bit flipped: -32768 -> 0x00, 0 -> 0x80.
  function automatic logic [PIXEL_W-1:0] to_offset_binary(
    input logic [PIXEL_W-1:0] sample_hi
  );
    return {~sample_hi[PIXEL_W-1], sample_hi[PIXEL_W-2:0]};
  endfunction

endpackage

// File: rtl/zero_cross_detect.sv
// Positive-going zero-crossing detector: remembers the previous strobed sample
// and flags a strobe whose sample is non-negative after a negative one.
module zero_cross_detect
  import wave_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strobe_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic                crossing_o
);

  logic [SAMPLE_W-1:0] prev_q;
  logic [SAMPLE_W-1:0] prev_d;
  logic                unused_prev_lsbs;

  always_comb begin
    prev_d = prev_q;
    if (strobe_i) begin
      prev_d = sample_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // Only the sign of the previous sample takes part in the compare.
  assign unused_prev_lsbs = ^prev_q[SAMPLE_W-2:0];
  assign crossing_o = strobe_i & prev_q[SAMPLE_W-1] & ~sample_i[SAMPLE_W-1];

endmodule

// File: rtl/wave_capture.sv
// Triggered waveform capture into a double-buffered sample RAM: 256 samples per
// capture starting at a positive zero crossing, half swapped when the display idles.
// Optional build macro WAVE_CAPTURE_AUTOTRIG_EN forces a trigger after
// AUTOTRIG_SAMPLES strobes spent in ARMED.
module wave_capture
  import wave_pkg::*;
#(
  parameter int AUTOTRIG_SAMPLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [RAM_AW-1:0]   write_address,
  output logic                write_enable,
  output logic [PIXEL_W-1:0]  write_sample,
  output logic                read_index
);

  cap_state_e           state_q, state_d;
  logic [OFFSET_W-1:0]  count_q, count_d;
  logic                 read_index_q, read_index_d;
  logic                 we_q, we_d;
  logic [RAM_AW-1:0]    waddr_q, waddr_d;
  logic [PIXEL_W-1:0]   wsample_q, wsample_d;

  logic                 crossing;
  logic                 auto_fire;
  logic                 trigger;
  logic                 write_now;
  logic [OFFSET_W-1:0]  offset;
  logic                 unused_sample_lsbs;

  zero_cross_detect u_zero_cross (
    .clk_i      (clk),
    .rst_i      (reset),
    .strobe_i   (new_sample_ready),
    .sample_i   (new_sample_in),
    .crossing_o (crossing)
  );

  assign unused_sample_lsbs = ^new_sample_in[SAMPLE_W-PIXEL_W-1:0];

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  localparam int ACW = $clog2(AUTOTRIG_SAMPLES + 1);

  logic [ACW-1:0] armed_cnt_q, armed_cnt_d;

  // Held at zero outside ARMED so every entry into ARMED starts a fresh count.
  always_comb begin
    armed_cnt_d = '0;
    if (state_q == ST_ARMED) begin
      armed_cnt_d = armed_cnt_q;
      if (new_sample_ready) begin
        armed_cnt_d = trigger ? '0 : armed_cnt_q + ACW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_cnt_q <= '0;
    end else begin
      armed_cnt_q <= armed_cnt_d;
    end
  end

  assign auto_fire = new_sample_ready && (armed_cnt_q == ACW'(AUTOTRIG_SAMPLES - 1));
`else
  assign auto_fire = 1'b0;
`endif

  assign trigger = (state_q == ST_ARMED) && (crossing || auto_fire);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    read_index_d = read_index_q;
    write_now    = 1'b0;
    offset       = count_q;

    unique case (state_q)
      ST_ARMED: begin
        if (trigger) begin
          write_now = 1'b1;
          offset    = '0;
          count_d   = OFFSET_W'(1);
          state_d   = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (new_sample_ready) begin
          write_now = 1'b1;
          count_d   = count_q + OFFSET_W'(1);
          if (count_q == OFFSET_W'(CAPTURE_LEN - 1)) begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Strobes are dropped here; the half swap waits for the display to go idle.
        if (wave_display_idle) begin
          read_index_d = ~read_index_q;
          state_d      = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_ARMED;
      end
    endcase
  end

  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wsample_d = wsample_q;
    if (write_now) begin
      we_d      = 1'b1;
      waddr_d   = {~read_index_q, offset};
      wsample_d = to_offset_binary(new_sample_in[SAMPLE_W-1:SAMPLE_W-PIXEL_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARMED;
      count_q      <= '0;
      read_index_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wsample_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      read_index_q <= read_index_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wsample_q    <= wsample_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = waddr_q;
  assign write_sample  = wsample_q;
  assign read_index    = read_index_q;

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter AUTOTRIG_SAMPLES, default 1024, meaning the armed-state sample count before a forced trigger (used only when WAVE_CAPTURE_AUTOTRIG_EN is defined).
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port new_sample_ready  input  1  one-cycle strobe marking new_sample_in valid.
REQ-005 SHALL have port new_sample_in  input  16  signed two's-complement audio sample.
REQ-006 SHALL have port wave_display_idle  input  1  high when the display is not scanning the waveform region.
REQ-007 SHALL have port write_address  output  9  sample RAM write address.
REQ-008 SHALL have port write_enable  output  1  one-cycle sample RAM write strobe.
REQ-009 SHALL have port write_sample  output  8  unsigned offset-binary sample for RAM.
REQ-010 SHALL have port read_index  output  1  selects the RAM half the display reads; the capture writes the other half.

Function
REQ-011 SHALL implement states ARMED, ACTIVE, WAIT.
REQ-012 SHALL register the previous sample (prev) on every new_sample_ready, in all states.
REQ-013 ARMED: on new_sample_ready with prev[15]=1 and new_sample_in[15]=0 (positive zero crossing), SHALL write that sample at offset 0, set count to 1 and go to ACTIVE.
REQ-014 ACTIVE: each new_sample_ready SHALL write the sample at offset count; count increments by 1.
REQ-015 The write of offset 255 SHALL move to WAIT; exactly 256 writes per capture; count is 8 bits and wraps to 0.
REQ-016 WAIT: new_sample_ready SHALL be ignored, with no write; when wave_display_idle=1, read_index SHALL toggle and the state SHALL return to ARMED in the same edge.
REQ-017 write_address SHALL be {~read_index, offset}.
REQ-018 write_sample SHALL be new_sample_in[15:8] with bit 7 inverted, i.e. +128 offset binary.
REQ-019 write_enable, write_address and write_sample SHALL be registered; write_enable is high for exactly the one cycle after the accepted strobe.
REQ-020 write_enable SHALL be 0 in every cycle not following an accepted strobe; write_address and write_sample hold their last values.
REQ-021 new_sample_ready coincident with wave_display_idle in WAIT SHALL be dropped for writing, but prev is still updated.
REQ-022 read_index SHALL change only on the WAIT-to-ARMED transition.

Reset
REQ-023 reset SHALL force state ARMED, count 0, prev 0, read_index 0, write_enable 0, write_address 0, write_sample 0.
REQ-024 reset asserted mid-capture SHALL abort the capture with no further writes; the next capture restarts at offset 0 in half 1.
REQ-025 reset SHALL take precedence over every simultaneous event.

Configuration
REQ-026 With WAVE_CAPTURE_AUTOTRIG_EN defined, an armed-sample counter SHALL count strobes in ARMED, clear on entry to ARMED, and force a trigger on the AUTOTRIG_SAMPLES-th strobe, with identical behaviour to REQ-013.
REQ-027 Without the macro, the counter and parameter use SHALL be absent; ARMED SHALL wait indefinitely for a crossing.

Structure
REQ-028 State encodings, SAMPLE_W=16, RAM_AW=9 and CAPTURE_LEN=256 SHALL live in a shared package wave_pkg, which wave_display also uses.
REQ-029 The crossing detector (prev register plus compare) SHALL be sub-module zero_cross_detect; everything else is flat.

Verification
REQ-030 After reset, strobe samples -5, then +3: one write, address 9'h100, data 8'h80, write_enable high one cycle; state ACTIVE.
REQ-031 Continue with 255 further strobes of value 16'h7F00: addresses 9'h101..9'h1FF, data 8'hFF; then WAIT; a 257th strobe produces no write.
REQ-032 In WAIT, assert wave_display_idle for one cycle: read_index goes 0 to 1; the next triggered capture writes addresses 9'h000..9'h0FF.
REQ-033 Strobe only positive samples for 2000 strobes: no writes without WAVE_CAPTURE_AUTOTRIG_EN; with the macro, the first write at the 1024th strobe.
REQ-034 Assert reset after 100 capture writes: the next cycle write_enable=0 and read_index=0; re-trigger writes start at 9'h100.
REQ-035 Sample 16'h8000 written: data 8'h00; sample 16'h0000: data 8'h80.
